// File: rtl/cpu_bus_arb_pkg.sv
// Shared constants and encodings for the CPU bus arbiter and its OAM sprite-DMA engine.
package cpu_bus_arb_pkg;

    localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

    typedef enum logic [1:0] {
        OWN_CPU = 2'd0,
        OWN_DBG = 2'd1,
        OWN_DMA = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_ALIGN = 2'd1,
        DMA_RD    = 2'd2,
        DMA_WR    = 2'd3
    } dma_state_e;

endpackage

// File: rtl/cpu_bus_arb_oam_dma.sv
// OAM sprite-DMA engine: copies one 256-byte page to the OAM data port, pausing
// in place whenever the arbiter reports that another master owns the bus.
module oam_dma
    import cpu_bus_arb_pkg::*;
#(
    parameter logic [15:0] OamAddr = OAM_DATA_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pause,
    input  logic        trig,
    input  logic [7:0]  trig_page,
    input  logic [7:0]  mem_din,
    output logic        busy,
    output logic [15:0] dma_a,
    output logic [7:0]  dma_dout,
    output logic        dma_r_nw
);

    dma_state_e state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    // Set for the one cycle in which mem_din carries the result of the issued RD.
    logic       fresh_q, fresh_d;
    logic [7:0] wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DMA_IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            data_q  <= 8'h00;
            fresh_q <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            fresh_q <= fresh_d;
        end
    end

    assign wr_data = fresh_q ? mem_din : data_q;

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        data_d  = wr_data;
        fresh_d = 1'b0;
        unique case (state_q)
            DMA_IDLE: begin
                if (trig) begin
                    state_d = DMA_ALIGN;
                    page_d  = trig_page;
                    idx_d   = 8'h00;
                end
            end
            DMA_ALIGN: begin
                if (!pause) state_d = DMA_RD;
            end
            DMA_RD: begin
                if (!pause) begin
                    state_d = DMA_WR;
                    fresh_d = 1'b1;
                end
            end
            DMA_WR: begin
                if (!pause) begin
                    idx_d   = idx_q + 8'd1;
                    state_d = (idx_q == 8'hFF) ? DMA_IDLE : DMA_RD;
                end
            end
            default: state_d = DMA_IDLE;
        endcase
    end

    assign busy     = (state_q != DMA_IDLE);
    assign dma_a    = (state_q == DMA_WR) ? OamAddr : {page_q, idx_q};
    assign dma_r_nw = (state_q != DMA_WR);
    assign dma_dout = wr_data;

endmodule

// File: rtl/cpu_bus_arb.sv
// Shared CPU memory bus arbiter: debug > OAM DMA > CPU, with the DMA engine
// triggered by a CPU write to the trigger address.
module cpu_bus_arb
    import cpu_bus_arb_pkg::*;
#(
    parameter logic [15:0] TrigAddr = DMA_TRIG_ADDR,
    parameter logic [15:0] OamAddr  = OAM_DATA_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_a_in,
    input  logic [7:0]  cpu_dout_in,
    input  logic        cpu_r_nw_in,
    output logic        cpu_rdy,
    input  logic        dbg_active,
    input  logic [15:0] dbg_a,
    input  logic [7:0]  dbg_dout,
    input  logic        dbg_r_nw,
    output logic [15:0] mem_a,
    output logic [7:0]  mem_dout,
    output logic        mem_r_nw,
    input  logic [7:0]  mem_din,
    output logic        dma_busy
);

    owner_e      owner;
    logic        trig;
    logic [15:0] dma_a;
    logic [7:0]  dma_dout;
    logic        dma_r_nw;

    always_comb begin
        owner = OWN_CPU;
        if (dbg_active) begin
            owner = OWN_DBG;
        end else if (dma_busy) begin
            owner = OWN_DMA;
        end
    end

    // Only a CPU that actually owns the bus can start a transfer.
    assign trig    = (owner == OWN_CPU) && !cpu_r_nw_in && (cpu_a_in == TrigAddr);
    assign cpu_rdy = (owner == OWN_CPU);

    oam_dma #(
        .OamAddr (OamAddr)
    ) u_oam_dma (
        .clk       (clk),
        .rst       (rst),
        .pause     (dbg_active),
        .trig      (trig),
        .trig_page (cpu_dout_in),
        .mem_din   (mem_din),
        .busy      (dma_busy),
        .dma_a     (dma_a),
        .dma_dout  (dma_dout),
        .dma_r_nw  (dma_r_nw)
    );

    always_comb begin
        mem_a    = cpu_a_in;
        mem_dout = cpu_dout_in;
        mem_r_nw = cpu_r_nw_in;
        case (owner)
            OWN_DBG: begin
                mem_a    = dbg_a;
                mem_dout = dbg_dout;
                mem_r_nw = dbg_r_nw;
            end
            OWN_DMA: begin
                mem_a    = dma_a;
                mem_dout = dma_dout;
                mem_r_nw = dma_r_nw;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_bus_arb.sv
// Bench for cpu_bus_arb: directed bus scenarios; OAM writes are checked by a
// scoreboard monitor against a queue of expected bytes.
module tb_cpu_bus_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_a_in;
    logic [7:0]  cpu_dout_in;
    logic        cpu_r_nw_in;
    logic        cpu_rdy;
    logic        dbg_active;
    logic [15:0] dbg_a;
    logic [7:0]  dbg_dout;
    logic        dbg_r_nw;
    logic [15:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_r_nw;
    logic [7:0]  mem_din;
    logic        dma_busy;

    int checks = 0;
    int fails  = 0;
    logic [7:0] exp_q[$];

    cpu_bus_arb u_dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_a_in    (cpu_a_in),
        .cpu_dout_in (cpu_dout_in),
        .cpu_r_nw_in (cpu_r_nw_in),
        .cpu_rdy     (cpu_rdy),
        .dbg_active  (dbg_active),
        .dbg_a       (dbg_a),
        .dbg_dout    (dbg_dout),
        .dbg_r_nw    (dbg_r_nw),
        .mem_a       (mem_a),
        .mem_dout    (mem_dout),
        .mem_r_nw    (mem_r_nw),
        .mem_din     (mem_din),
        .dma_busy    (dma_busy)
    );

    always #5 clk = ~clk;

    // Read-only memory image: page 2 holds i^5A, everything else a different pattern.
    function automatic logic [7:0] mem_val(input logic [15:0] a);
        if (a[15:8] == 8'h02) return a[7:0] ^ 8'h5A;
        return a[7:0] ^ 8'hC3;
    endfunction

    always @(posedge clk) mem_din <= mem_val(mem_a);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every OAM write must match the next expected byte.
    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (mem_r_nw === 1'b0 && mem_a === 16'h2004) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_oam_write: got data %0h expected no write at %0t",
                             mem_dout, $time);
                end else begin
                    exp = exp_q.pop_front();
                    if (mem_dout !== exp) begin
                        fails++;
                        $display("FAIL oam_data: got %0h expected %0h at %0t", mem_dout, exp, $time);
                    end
                end
            end
        end
    end

    task automatic push_page(input logic [7:0] page, input int count);
        for (int i = 0; i < count; i++) exp_q.push_back(mem_val({page, 8'(i)}));
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        cpu_a_in    = 16'h0000;
        cpu_dout_in = 8'h00;
        cpu_r_nw_in = 1'b1;
        dbg_active  = 1'b0;
    endtask

    task automatic run_dma(input logic [7:0] page, input int pulse_at, input int pulse_len,
                           input int rst_at, output int stall);
        int busy_err;
        int mux_err;
        bit done;
        busy_err = 0;
        mux_err  = 0;
        stall    = 0;
        done     = 1'b0;
        @(posedge clk);
        #1;
        cpu_a_in    = 16'h4014;
        cpu_dout_in = page;
        cpu_r_nw_in = 1'b0;
        @(negedge clk);
        check("trig_cpu_rdy", cpu_rdy, 1);
        check("trig_mem_a", mem_a, 16'h4014);
        check("trig_mem_r_nw", mem_r_nw, 0);
        for (int k = 1; k < 2000 && !done; k++) begin
            @(posedge clk);
            #1;
            cpu_a_in    = 16'h0000;
            cpu_r_nw_in = 1'b1;
            dbg_active  = (pulse_len > 0) && (k >= pulse_at) && (k < pulse_at + pulse_len);
            rst         = (rst_at > 0) && (k == rst_at);
            @(negedge clk);
            if (rst_at > 0 && k == rst_at + 1) begin
                check("rst_dma_busy", dma_busy, 0);
                check("rst_cpu_rdy", cpu_rdy, 1);
                done = 1'b1;
            end else if (cpu_rdy) begin
                done = 1'b1;
            end else begin
                stall++;
                if (dma_busy !== 1'b1) busy_err++;
                if (dbg_active && (mem_a !== dbg_a || mem_r_nw !== dbg_r_nw)) mux_err++;
            end
        end
        rst        = 1'b0;
        dbg_active = 1'b0;
        check("dma_done_in_bound", done, 1);
        check("busy_tracks_stall", busy_err, 0);
        check("pause_mux_dbg", mux_err, 0);
    endtask

    initial begin
        int stall;
        rst         = 1'b1;
        cpu_a_in    = 16'h1111;
        cpu_dout_in = 8'h00;
        cpu_r_nw_in = 1'b1;
        dbg_active  = 1'b0;
        dbg_a       = 16'h0010;
        dbg_dout    = 8'h00;
        dbg_r_nw    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_dma_busy", dma_busy, 0);
        check("reset_cpu_rdy", cpu_rdy, 1);
        check("reset_mem_a_cpu", mem_a, 16'h1111);

        // Plain DMA of page 2.
        push_page(8'h02, 256);
        run_dma(8'h02, 0, 0, 0, stall);
        check("stall_plain", stall, 513);
        check("oam_count_plain", exp_q.size(), 0);

        // Debug pulse of 10 cycles starting at WR idx 0x40 (T+131).
        push_page(8'h02, 256);
        run_dma(8'h02, 131, 10, 0, stall);
        check("stall_paused", stall, 523);
        check("oam_count_paused", exp_q.size(), 0);

        // Reset at RD idx 0x80 (T+258): only bytes 0..7F reach OAM.
        push_page(8'h02, 128);
        run_dma(8'h02, 0, 0, 258, stall);
        repeat (6) idle_cycle();
        @(negedge clk);
        check("rst_no_more_oam", exp_q.size(), 0);
        check("rst_idle_busy", dma_busy, 0);

        // Debug write to $4014 passes through but never triggers.
        @(posedge clk);
        #1;
        dbg_active = 1'b1;
        dbg_a      = 16'h4014;
        dbg_dout   = 8'h03;
        dbg_r_nw   = 1'b0;
        @(negedge clk);
        check("dbgw_mem_a", mem_a, 16'h4014);
        check("dbgw_mem_dout", mem_dout, 8'h03);
        check("dbgw_mem_r_nw", mem_r_nw, 0);
        check("dbgw_cpu_rdy", cpu_rdy, 0);
        idle_cycle();
        dbg_r_nw = 1'b1;
        @(negedge clk);
        check("dbgw_no_dma", dma_busy, 0);

        // CPU read of $4014, then CPU write to $4015: neither triggers.
        @(posedge clk);
        #1;
        cpu_a_in    = 16'h4014;
        cpu_dout_in = 8'h02;
        cpu_r_nw_in = 1'b1;
        @(negedge clk);
        check("cpur_mem_a", mem_a, 16'h4014);
        check("cpur_mem_r_nw", mem_r_nw, 1);
        @(posedge clk);
        #1;
        cpu_a_in    = 16'h4015;
        cpu_r_nw_in = 1'b0;
        @(negedge clk);
        check("cpur_no_dma", dma_busy, 0);
        check("cpuw_mem_a", mem_a, 16'h4015);
        check("cpuw_mem_dout", mem_dout, 8'h02);
        check("cpuw_mem_r_nw", mem_r_nw, 0);
        idle_cycle();
        @(negedge clk);
        check("cpuw_no_dma", dma_busy, 0);

        // Debug owns the bus in the very cycle the CPU writes $4014.
        @(posedge clk);
        #1;
        cpu_a_in    = 16'h4014;
        cpu_dout_in = 8'h02;
        cpu_r_nw_in = 1'b0;
        dbg_active  = 1'b1;
        dbg_a       = 16'h1234;
        dbg_dout    = 8'h77;
        dbg_r_nw    = 1'b1;
        @(negedge clk);
        check("dbgtrig_mem_a", mem_a, 16'h1234);
        check("dbgtrig_mem_dout", mem_dout, 8'h77);
        check("dbgtrig_mem_r_nw", mem_r_nw, 1);
        check("dbgtrig_cpu_rdy", cpu_rdy, 0);
        idle_cycle();
        @(negedge clk);
        check("dbgtrig_no_dma", dma_busy, 0);
        check("dbgtrig_cpu_rdy_after", cpu_rdy, 1);
        repeat (4) idle_cycle();
        @(negedge clk);
        check("final_oam_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
